// File: rtl/aes_pkg.sv
// AES shared constants for the byte-substitution datapath.
//   AES_BYTE_W : width of one AES state byte
//   SBOX_FWD   : forward S-box (SubBytes), indexed by input byte
//   SBOX_INV   : inverse S-box (InvSubBytes), indexed by input byte
package aes_pkg;

  localparam int AES_BYTE_W = 8;

  localparam logic [7:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One-byte S-box lookup, purely combinational.
//   din  : input byte
//   inv  : 0 = forward table, 1 = inverse table
//   dout : substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] din,
  input  logic                  inv,
  output logic [AES_BYTE_W-1:0] dout
);

  always_comb begin
    dout = 8'h00;
    case (inv)
      1'b0:    dout = SBOX_FWD[din];
      1'b1:    dout = SBOX_INV[din];
      default: dout = 8'h00;  // unreachable with a fully decoded select
    endcase
  end

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage pipelined AES SubBytes / InvSubBytes engine, LANES bytes per beat.
//   clk, rst             : clock, async active-high reset
//   flush                : synchronous clear of all beats in flight
//   in_valid/in_ready    : input handshake; in_inv, in_data, in_tag = beat fields
//   out_valid/out_ready  : output handshake; out_data, out_tag = result fields
// Handshake: a beat transfers on a rising edge where valid && ready; the
// producer holds valid and its fields stable until that edge. in_ready is
// combinational from out_ready and flush; out_* come straight from flops.
module aes_sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 16,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_inv,
  input  logic [AES_BYTE_W*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AES_BYTE_W*LANES-1:0] out_data,
  output logic [TAG_W-1:0]            out_tag
);

  logic                        s1_v;
  logic                        s1_inv;
  logic [AES_BYTE_W*LANES-1:0] s1_data;
  logic [TAG_W-1:0]            s1_tag;
  logic                        s2_v;
  logic [AES_BYTE_W*LANES-1:0] s2_data;
  logic [TAG_W-1:0]            s2_tag;
  logic [AES_BYTE_W*LANES-1:0] lut_data;
  logic                        s1_adv;
  logic                        s2_adv;

  // A stage may advance when it is empty or its successor is advancing.
  assign s2_adv   = !s2_v || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv && !flush;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .din  (s1_data[AES_BYTE_W*i +: AES_BYTE_W]),
      .inv  (s1_inv),
      .dout (lut_data[AES_BYTE_W*i +: AES_BYTE_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_inv  <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_tag  <= '0;
    end else if (flush) begin
      // flush overrides every load; payload registers simply hold
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_data <= lut_data;
          s2_tag  <= s1_tag;
        end
      end
      if (s1_adv) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_inv  <= in_inv;
          s1_data <= in_data;
          s1_tag  <= in_tag;
        end
      end
    end
  end

  assign out_valid = s2_v;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
module tb_aes_sub_bytes_pipe;

  localparam int LANES = 16;
  localparam int TAG_W = 4;
  localparam int DW    = 8 * LANES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             flush, in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [DW-1:0]    in_data, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;

  aes_sub_bytes_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Forward S-box from its definition: multiplicative inverse in GF(2^8)
  // modulo x^8+x^4+x^3+x+1, then the AES affine map. Inverse table by inversion.
  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] iv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) iv = 8'(c);
      fwd_m[a] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_m[fwd_m[a]] = 8'(a);
  end

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[8*l +: 8] = inv ? inv_m[d[8*l +: 8]] : fwd_m[d[8*l +: 8]];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0]    exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  int               cyc_q[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); tag_q.delete(); cyc_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", DW'(out_valid), DW'(0));
        end else begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_tag", DW'(out_tag), DW'(tag_q[0]));
          if (check_lat) chk("latency", DW'(cyc - cyc_q[0]), DW'(2));
          if (out_ready) begin
            void'(exp_q.pop_front()); void'(tag_q.pop_front()); void'(cyc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_inv));
        tag_q.push_back(in_tag);
        cyc_q.push_back(cyc);
      end
      if (flush) begin
        exp_q.delete(); tag_q.delete(); cyc_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [DW-1:0] d, input logic inv, input logic [TAG_W-1:0] t);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_inv = inv; in_tag = t;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", DW'(0), DW'(1));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", DW'(exp_q.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    int acc;
    bit a;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
    in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_out_tag", DW'(out_tag), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(1));

    // pin the model with known S-box values
    chk("pin_fwd_00", DW'(fwd_m[8'h00]), DW'(8'h63));
    chk("pin_fwd_53", DW'(fwd_m[8'h53]), DW'(8'hed));
    chk("pin_fwd_ff", DW'(fwd_m[8'hff]), DW'(8'h16));
    chk("pin_fwd_52", DW'(fwd_m[8'h52]), DW'(8'h00));
    chk("pin_inv_63", DW'(inv_m[8'h63]), DW'(8'h00));
    chk("pin_inv_ed", DW'(inv_m[8'hed]), DW'(8'h53));

    // directed forward vector with literal output check
    @(posedge clk); #1;
    check_lat = 1'b1;
    d = rnd_data(); d[31:0] = 32'h52ff5300;
    drive(d, 1'b0, 4'ha);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("fwd_vec_lanes", DW'(out_data[31:0]), DW'(32'h0016ed63));
    chk("fwd_vec_tag", DW'(out_tag), DW'(4'ha));
    chk("fwd_vec_valid", DW'(out_valid), DW'(1));
    @(posedge clk); #1;

    // directed inverse vector
    d = rnd_data(); d[31:0] = 32'h0016ed63;
    drive(d, 1'b1, 4'h5);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("inv_vec_lanes", DW'(out_data[31:0]), DW'(32'h52ff5300));
    chk("inv_vec_tag", DW'(out_tag), DW'(4'h5));
    @(posedge clk); #1;

    // full-byte sweep forward, then the forward images back through inverse
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < LANES; l++) d[8*l +: 8] = 8'(16*b + l);
      drive(d, 1'b0, 4'(b));
    end
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < LANES; l++) d[8*l +: 8] = fwd_m[16*b + l];
      drive(d, 1'b1, 4'(b));
    end
    drain();

    // alternating modes, back-to-back; latency check proves no bubbles
    for (int b = 0; b < 8; b++) drive(rnd_data(), 1'(b & 1), 4'($urandom_range(0, 15)));
    drain();
    check_lat = 1'b0;

    // backpressure: out_ready low for 5 cycles with in_valid high
    out_ready = 1'b0; acc = 0;
    in_valid = 1'b1; in_data = rnd_data(); in_inv = 1'($urandom_range(0, 1)); in_tag = 4'h3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (acc >= 2) chk("bp_in_ready_low", DW'(in_ready), DW'(0));
      a = in_ready;
      if (a) acc++;
      @(posedge clk); #1;
      if (a) begin in_data = rnd_data(); in_inv = ~in_inv; in_tag = in_tag + 4'h1; end
    end
    chk("bp_accept_count", DW'(acc), DW'(2));
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", DW'(in_ready), DW'(1));
    drain();

    // flush with two beats in flight; a beat offered during flush is refused
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(rnd_data(), 1'b0, 4'h1);
    drive(rnd_data(), 1'b1, 4'h2);
    in_valid = 1'b1; in_data = rnd_data(); in_tag = 4'h7; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", DW'(in_ready), DW'(0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", DW'(out_valid), DW'(0));
    out_ready = 1'b1;
    idle(6);

    // async reset between edges while streaming
    check_lat = 1'b1;
    for (int b = 0; b < 3; b++) drive(rnd_data(), 1'(b & 1), 4'hf);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", DW'(out_valid), DW'(0));
    chk("arst_out_data", out_data, DW'(0));
    chk("arst_out_tag", DW'(out_tag), DW'(0));
    in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    drive(rnd_data(), 1'b1, 4'h9);
    drain();
    check_lat = 1'b0;

    // randomized traffic with random backpressure and rare flushes
    in_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      a = in_valid && in_ready;
      @(posedge clk); #1;
      flush = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || a) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rnd_data();
        in_inv   = 1'($urandom_range(0, 1));
        in_tag   = 4'($urandom_range(0, 15));
      end
    end
    flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
